// File: rtl/sar_result_capture_if.sv
// Sequencer, comparator and downstream handshake signals of the SAR result capture block.
// The slave modport is the capture block's view; the master modport drives it.
interface sar_result_capture_if;
  logic       SAR_RESET;
  logic [6:0] OUTEN;
  logic       VCOMP;
  logic       DREADY;
  logic [7:0] DOUT;
  logic       DVALID;
  logic       BUSY;
  logic       SEQERR;
  logic       OVERRUN;

  modport slave (
    input  SAR_RESET, OUTEN, VCOMP, DREADY,
    output DOUT, DVALID, BUSY, SEQERR, OVERRUN
  );

  modport master (
    output SAR_RESET, OUTEN, VCOMP, DREADY,
    input  DOUT, DVALID, BUSY, SEQERR, OVERRUN
  );
endinterface

// File: rtl/sar_result_capture.sv
// Collects one comparator decision per SAR bit phase, checks the phase order and hands
// completed 8-bit codes downstream through a valid/ready register with overrun detection.
module sar_result_capture #(
  parameter bit COMP_INV = 1'b0
) (
  input  logic                 CLK,
  input  logic                 RESET,
  sar_result_capture_if.slave  sar
);

  typedef enum logic [1:0] {IDLE, ARMED, CONV, LSB} state_t;

  state_t     state_q, state_d;
  logic [2:0] k_q, k_d;
  logic [7:1] part_q, part_d;
  logic [7:0] dout_q, dout_d;
  logic       dvalid_q, dvalid_d;
  logic       seqerr_q, seqerr_d;
  logic       overrun_q, overrun_d;

  logic       bit_eff;
  logic       complete;
  logic       xfer;
  logic [6:0] exp_onehot;

  assign bit_eff    = sar.VCOMP ^ COMP_INV;
  assign exp_onehot = 7'b1 << (k_q - 3'd1);
  assign xfer       = dvalid_q & sar.DREADY;

  // Bits 7..1 are shifted in MSB first, so after the last bit phase part_q holds them in order.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d  = state_q;
    k_d      = k_q;
    part_d   = part_q;
    seqerr_d = 1'b0;
    complete = 1'b0;

    case (state_q)
      IDLE: begin
        if (sar.SAR_RESET) state_d = ARMED;
      end
      ARMED: begin
        if (!sar.SAR_RESET) begin
          if (sar.OUTEN == 7'b1000000) begin
            part_d  = {part_q[6:1], bit_eff};
            k_d     = 3'd6;
            state_d = CONV;
          end else begin
            seqerr_d = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      CONV: begin
        if (sar.SAR_RESET) begin
          seqerr_d = 1'b1;
          k_d      = 3'd7;
          state_d  = ARMED;
        end else if (sar.OUTEN == exp_onehot) begin
          part_d = {part_q[6:1], bit_eff};
          if (k_q == 3'd1) state_d = LSB;
          else             k_d     = k_q - 3'd1;
        end else begin
          seqerr_d = 1'b1;
          k_d      = 3'd7;
          state_d  = IDLE;
        end
      end
      LSB: begin
        k_d = 3'd7;
        if (sar.SAR_RESET) begin
          seqerr_d = 1'b1;
          state_d  = ARMED;
        end else if (sar.OUTEN == 7'b0) begin
          complete = 1'b1;
          state_d  = IDLE;
        end else begin
          seqerr_d = 1'b1;
          state_d  = IDLE;
        end
      end
      default: begin
        k_d     = 3'd7;
        state_d = IDLE;
      end
    endcase
  end

  // A transfer frees the output register first, so a completion at the same edge still lands.
  always_comb begin
    dout_d    = dout_q;
    dvalid_d  = dvalid_q;
    overrun_d = overrun_q;

    if (xfer) begin
      dvalid_d  = 1'b0;
      overrun_d = 1'b0;
    end

    if (complete) begin
      if (!dvalid_q || xfer) begin
        dout_d   = {part_q, bit_eff};
        dvalid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= IDLE;
      k_q       <= 3'd7;
      part_q    <= '0;
      dout_q    <= 8'h00;
      dvalid_q  <= 1'b0;
      seqerr_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      k_q       <= k_d;
      part_q    <= part_d;
      dout_q    <= dout_d;
      dvalid_q  <= dvalid_d;
      seqerr_q  <= seqerr_d;
      overrun_q <= overrun_d;
    end
  end

  assign sar.DOUT    = dout_q;
  assign sar.DVALID  = dvalid_q;
  assign sar.BUSY    = (state_q != IDLE);
  assign sar.SEQERR  = seqerr_q;
  assign sar.OVERRUN = overrun_q;

endmodule

// File: doc/sar_result_capture.md
SAR_RESULT_CAPTURE -- requirements
Module: sar_result_capture

Interface
REQ-001 SHALL provide parameter COMP_INV, default 0, meaning: 1 = invert VCOMP before capture.
REQ-002 SHALL have port CLK  input  1  single system clock; all flops rising-edge.
REQ-003 SHALL have port RESET  input  1  asynchronous, active-low reset (0 = reset).
REQ-004 SHALL have port SAR_RESET  input  1  sample-phase indicator from the SAR sequencer.
REQ-005 SHALL have port OUTEN  input  7  one-hot bit-phase enables from the sequencer; bit 6 = MSB (bit7) phase, bit 0 = bit1 phase.
REQ-006 SHALL have port VCOMP  input  1  comparator decision; 1 = bit kept.
REQ-007 SHALL have port DREADY  input  1  downstream ready.
REQ-008 SHALL have port DOUT  output  8  last completed conversion code.
REQ-009 SHALL have port DVALID  output  1  DOUT holds an untransferred code.
REQ-010 SHALL have port BUSY  output  1  conversion in progress (state ARMED, CONV or LSB).
REQ-011 SHALL have port SEQERR  output  1  one-cycle pulse on a protocol violation.
REQ-012 SHALL have port OVERRUN  output  1  sticky flag: a completed code was dropped.

Function
REQ-013 SHALL implement states IDLE, ARMED, CONV and LSB, plus a 3-bit expected-bit index K (7..1).
REQ-014 SHALL sample all inputs at each CLK rising edge; the effective comparator bit SHALL be VCOMP XOR COMP_INV.
REQ-015 In IDLE: SAR_RESET=1 -> ARMED; any other input SHALL be ignored without SEQERR.
REQ-016 In ARMED: SAR_RESET=1 -> stay ARMED; SAR_RESET=0 with OUTEN=7'b1000000 -> capture bit7, K=6, go to CONV; any other input -> SEQERR, go to IDLE.
REQ-017 In CONV: SAR_RESET=0 with OUTEN equal to one-hot at position K-1 -> capture bit K; if K=1 go to LSB, else decrement K.
REQ-018 In LSB: SAR_RESET=0 with OUTEN=0 -> capture bit0, load all 8 bits into DOUT, complete, go to IDLE.
REQ-019 In CONV or LSB, SAR_RESET=1 SHALL abort: discard the partial code, pulse SEQERR, go to ARMED.
REQ-020 In CONV or LSB, any other OUTEN value (zero, multi-hot, wrong position) SHALL pulse SEQERR, discard the partial code and go to IDLE.
REQ-021 A conversion SHALL take 9 edges (1 SAR_RESET edge, 7 OUTEN edges, 1 LSB edge); DVALID SHALL be visible the cycle after the LSB edge.
REQ-022 A transfer SHALL occur when DVALID=1 and DREADY=1 at an edge; it clears DVALID unless a completion occurs at the same edge.
REQ-023 Completion with DVALID=0, or at the same edge as a transfer, SHALL load DOUT and set DVALID=1, with no overrun.
REQ-024 Completion with DVALID=1 and DREADY=0 SHALL drop the new code, keep DOUT, and set OVERRUN.
REQ-025 OVERRUN SHALL clear only on reset or on the next transfer edge; if overrun and transfer coincide, the transfer SHALL win and OVERRUN SHALL stay 0.
REQ-026 DOUT SHALL be stable while DVALID=1 and DREADY=0; partial codes SHALL never appear on DOUT.
REQ-027 Back-to-back conversions (LSB edge followed directly by a SAR_RESET=1 edge) SHALL be accepted with no idle gap.

Reset
REQ-028 RESET=0 SHALL asynchronously force state IDLE, K=7, DOUT=8'h00, DVALID=0, BUSY=0, SEQERR=0, OVERRUN=0.
REQ-029 Deassertion of RESET SHALL take effect at the next CLK edge; the first conversion SHALL require a fresh SAR_RESET=1 edge.
REQ-030 RESET asserted mid-conversion SHALL discard the partial code and any pending DOUT.

Verification
REQ-031 Nominal: DREADY=1, sequence SAMPLE, BIT7..BIT1, BIT0 with VCOMP = 1,0,1,1,0,0,1,0 -> DOUT=8'hB2, DVALID=1 for 1 cycle, SEQERR=0.
REQ-032 Backpressure: DREADY=0, two conversions of 8'h55 then 8'hAA -> DOUT stays 8'h55, OVERRUN=1; raise DREADY -> one transfer, DVALID=0, OVERRUN=0.
REQ-033 Protocol error: OUTEN=7'b0010000 arrives where 7'b0100000 is expected -> SEQERR pulses 1 cycle, BUSY=0, DOUT unchanged.
REQ-034 Abort: SAR_RESET=1 during BIT4 phase -> SEQERR pulse, ARMED; the following full conversion of 8'h0F -> DOUT=8'h0F.
REQ-035 COMP_INV=1, VCOMP held 0 for a full conversion -> DOUT=8'hFF; async RESET pulse mid-CONV -> all outputs at reset values immediately.
REQ-036 Simultaneous events: completion at the same edge as a transfer -> new code loaded, DVALID stays 1, OVERRUN=0.
